q_sync_sink: RTL and testbench

Clocked consumer at the output end of a Q-flop pipeline. Accepts tokens from the last `q_stage` over its four-phase successor handshake: that stage's `so` is the request, and this block's `si_ack` drives the stage's `si`. Each request is synchronized into the clock domain, the bundled data word is captured and the request acknowledged. Captured words are buffered in a small FIFO and presented to synchronous logic over a valid/ready interface.

---
 rtl/q_sync_sink_pkg.sv | 26 ++
 rtl/q_sync_sink_fifo.sv | 81 ++++++++
 rtl/q_sync_sink.sv | 117 +++++++++++
 tb/tb_q_sync_sink.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/q_sync_sink_pkg.sv
// -----------------------------------------------------------------------------
// q_sync_sink_pkg
// Shared definitions for the Q-pipeline clocked sink.
//   q_state_e          : handshake FSM state encoding (IDLE = 0, ACK_HI = 1)
//   Q_SYNC_STAGES_DEF  : default depth of the request synchronizer
//   Q_WIDTH_DEF        : default token data width
//   Q_DEPTH_DEF        : default FIFO depth
//   q_cnt_inc          : 16-bit wrapping increment for the transfer counter
// -----------------------------------------------------------------------------
package q_sync_sink_pkg;

  typedef enum logic {
    Q_IDLE   = 1'b0,
    Q_ACK_HI = 1'b1
  } q_state_e;

  localparam int Q_SYNC_STAGES_DEF = 2;
  localparam int Q_WIDTH_DEF       = 8;
  localparam int Q_DEPTH_DEF       = 4;

  // Natural 16-bit overflow gives the 65535 -> 0 wrap.
  function automatic logic [15:0] q_cnt_inc(input logic [15:0] cnt);
    return cnt + 16'd1;
  endfunction

endpackage

// File: rtl/q_sync_sink_fifo.sv
// -----------------------------------------------------------------------------
// q_sync_fifo
// First-word-fall-through FIFO used by q_sync_sink to buffer captured tokens.
//   clk, rst_n    : clock / async active-low reset (clears memory and pointers)
//   i_push        : write i_push_data (ignored when full)
//   i_push_data   : word to store
//   i_pop         : discard the head word (ignored when empty)
//   o_data        : head word, read combinationally from memory at read pointer
//   o_full        : occupancy == DEPTH
//   o_empty       : occupancy == 0
//   o_level       : occupancy, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap by overflow.
// -----------------------------------------------------------------------------
module q_sync_fifo
  import q_sync_sink_pkg::*;
#(
  parameter int WIDTH = Q_WIDTH_DEF,
  parameter int DEPTH = Q_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_push  = i_push & ~w_full;
  assign w_pop   = i_pop  & ~w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_push_data;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      // Push and pop together leave the occupancy unchanged.
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // When empty this still shows whatever sits at the read pointer, i.e. the
  // last word read there (or zero after reset).
  assign o_data  = r_mem[r_rptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_level = r_level;

endmodule

// File: rtl/q_sync_sink.sv
// -----------------------------------------------------------------------------
// q_sync_sink
// Clocked consumer at the end of a Q-flop pipeline. The last stage's four-phase
// request (so_req) is synchronized, the bundled data word captured into a FWFT
// FIFO and the request acknowledged (si_ack). Buffered words leave over a
// valid/ready interface. A full FIFO withholds the acknowledge, stalling the
// pipeline.
//   clk, rst_n : clock / async active-low reset
//   so_req     : asynchronous request from the last pipeline stage
//   data_in    : bundled data, stable from so_req rise until si_ack rise
//   si_ack     : registered acknowledge back to the last stage
//   out_data   : FIFO head word
//   out_valid  : FIFO non-empty
//   out_ready  : consumer takes the head word when out_valid && out_ready
//   level      : FIFO occupancy
//   xfer_cnt   : tokens accepted since reset, wrapping 16-bit
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// Q_IDLE   | si_ack low; waiting for a synchronized request with FIFO room
// Q_ACK_HI | si_ack high; word captured, waiting for the request to return low
// -----------------------------------------------------------------------------
module q_sync_sink
  import q_sync_sink_pkg::*;
#(
  parameter int WIDTH       = Q_WIDTH_DEF,
  parameter int DEPTH       = Q_DEPTH_DEF,
  parameter int SYNC_STAGES = Q_SYNC_STAGES_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     so_req,
  input  logic [WIDTH-1:0]         data_in,
  output logic                     si_ack,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              xfer_cnt
);

  logic [SYNC_STAGES-1:0] r_sync;
  q_state_e               r_state;
  logic                   r_ack;
  logic [15:0]            r_xfer;

  logic                   w_req_s;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;

  // Request synchronizer; the stage count also sets the settling margin for
  // data_in, which is sampled raw at the push edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], so_req};
    end
  end

  assign w_req_s = r_sync[SYNC_STAGES-1];

  // Full is taken from the registered level, so a pop on this edge only frees
  // room for a push on the next one.
  assign w_push = (r_state == Q_IDLE) && w_req_s && !w_full;
  assign w_pop  = !w_empty && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= Q_IDLE;
      r_ack   <= 1'b0;
      r_xfer  <= '0;
    end else begin
      case (r_state)
        Q_IDLE: begin
          if (w_req_s && !w_full) begin
            r_state <= Q_ACK_HI;
            r_ack   <= 1'b1;
            r_xfer  <= q_cnt_inc(r_xfer);
          end
        end
        Q_ACK_HI: begin
          if (!w_req_s) begin
            r_state <= Q_IDLE;
            r_ack   <= 1'b0;
          end
        end
        default: begin
          r_state <= Q_IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  q_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (data_in),
    .i_pop       (w_pop),
    .o_data      (out_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (level)
  );

  assign si_ack    = r_ack;
  assign out_valid = !w_empty;
  assign xfer_cnt  = r_xfer;

endmodule

// File: tb/tb_q_sync_sink.sv
module tb_q_sync_sink;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int SS    = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  so_req = 1'b0;
  logic [WIDTH-1:0]      data_in = '0;
  logic                  si_ack;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [$clog2(DEPTH):0] level;
  logic [15:0]           xfer_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: tokens in acknowledge order, words seen leaving the FIFO.
  logic [7:0] sent_q[$];
  logic [7:0] popped_q[$];
  int sent_rd  = 0;
  int pop_rd   = 0;
  int acc_base = 0;
  int pop_base = 0;
  int valid_cycles = 0;
  bit rand_rdy = 1'b0;

  q_sync_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .so_req    (so_req),
    .data_in   (data_in),
    .si_ack    (si_ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change only #1 after a rising edge, so what is seen here is what
  // the next rising edge acts on.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) valid_cycles++;
      if (out_valid && out_ready) popped_q.push_back(out_data);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int exp_level();
    return (sent_q.size() - acc_base) - (popped_q.size() - pop_base);
  endfunction

  function automatic int exp_xfer();
    return sent_q.size() - acc_base;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic mark_bases();
    acc_base = sent_q.size();
    sent_rd  = sent_q.size();
    pop_base = popped_q.size();
    pop_rd   = popped_q.size();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; so_req = 1'b0; out_ready = 1'b0; rand_rdy = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    mark_bases();
  endtask

  // Returns edges waited until si_ack == v, or -1 on timeout.
  task automatic wait_ack(input logic v, input int limit, output int cycles);
    cycles = 0;
    while (si_ack !== v && cycles < limit) begin
      tick();
      cycles++;
    end
    if (si_ack !== v) cycles = -1;
  endtask

  task automatic send_token(input logic [7:0] d, input int limit, output int cr, output int cf);
    data_in = d;
    so_req  = 1'b1;
    wait_ack(1'b1, limit, cr);
    if (cr >= 0) begin
      sent_q.push_back(d);
      data_in = 8'($urandom);
      so_req  = 1'b0;
      wait_ack(1'b0, limit, cf);
    end else begin
      cf = -1;
    end
  endtask

  task automatic drain(input int limit);
    out_ready = 1'b1;
    for (int i = 0; i < limit && out_valid; i++) tick();
    out_ready = 1'b0;
  endtask

  // Compares every not-yet-checked popped word with the acknowledge order.
  task automatic check_order(input string tag);
    while (pop_rd < popped_q.size()) begin
      n_checks++;
      if (sent_rd >= sent_q.size())
        $display("FAIL %s_order: got extra word %0h, expected none", tag, popped_q[pop_rd]);
      else if (popped_q[pop_rd] !== sent_q[sent_rd])
        $display("FAIL %s_order: got %0h expected %0h", tag, popped_q[pop_rd], sent_q[sent_rd]);
      else n_pass++;
      pop_rd++;
      sent_rd++;
    end
  endtask

  task automatic test_reset();
    int c;
    rst_n = 1'b0; so_req = 1'b1; data_in = 8'h3C; out_ready = 1'b0;
    tick(); tick();
    n_checks++; if (si_ack !== 1'b0) $display("FAIL rst_si_ack: got %b expected 0", si_ack); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 8'h00) $display("FAIL rst_out_data: got %0h expected 0", out_data); else n_pass++;
    n_checks++; if (level !== '0) $display("FAIL rst_level: got %0d expected 0", level); else n_pass++;
    n_checks++; if (xfer_cnt !== 16'd0) $display("FAIL rst_xfer_cnt: got %0d expected 0", xfer_cnt); else n_pass++;
    rst_n = 1'b1;
    mark_bases();
    wait_ack(1'b1, 10, c);
    n_checks++; if (c != SS + 1) $display("FAIL rst_ack_latency: got %0d expected %0d", c, SS + 1); else n_pass++;
    n_checks++; if (out_data !== 8'h3C) $display("FAIL rst_capture: got %0h expected 3c", out_data); else n_pass++;
    if (c >= 0) sent_q.push_back(8'h3C);
    so_req = 1'b0;
    wait_ack(1'b0, 10, c);
    n_checks++; if (c != SS + 1) $display("FAIL rst_ack_fall: got %0d expected %0d", c, SS + 1); else n_pass++;
  endtask

  task automatic test_single();
    int cr, cf, vb;
    do_reset();
    out_ready = 1'b1;
    vb = valid_cycles;
    send_token(8'hA5, 20, cr, cf);
    tick(); tick();
    n_checks++; if (cr != SS + 1) $display("FAIL single_ack_rise: got %0d expected %0d", cr, SS + 1); else n_pass++;
    n_checks++; if (cf != SS + 1) $display("FAIL single_ack_fall: got %0d expected %0d", cf, SS + 1); else n_pass++;
    n_checks++; if (valid_cycles - vb != 1) $display("FAIL single_valid_cycles: got %0d expected 1", valid_cycles - vb); else n_pass++;
    n_checks++; if (popped_q.size() - pop_base != 1) $display("FAIL single_pop_count: got %0d expected 1", popped_q.size() - pop_base); else n_pass++;
    check_order("single");
    n_checks++; if (xfer_cnt !== 16'(exp_xfer())) $display("FAIL single_xfer_cnt: got %0d expected %0d", xfer_cnt, exp_xfer()); else n_pass++;
    n_checks++; if (level !== 3'(exp_level())) $display("FAIL single_level: got %0d expected %0d", level, exp_level()); else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_fill_stall();
    int cr, cf;
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send_token(8'(i), 20, cr, cf);
      n_checks++; if (cr != SS + 1) $display("FAIL fill_ack_%0d: got %0d expected %0d", i, cr, SS + 1); else n_pass++;
    end
    n_checks++; if (level !== 3'(exp_level()) || exp_level() != DEPTH)
      $display("FAIL fill_level: got %0d expected %0d", level, DEPTH); else n_pass++;
    data_in = 8'h05;
    so_req  = 1'b1;
    wait_ack(1'b1, 20, cr);
    n_checks++; if (cr != -1) $display("FAIL stall_no_ack: got ack after %0d expected none in 20", cr); else n_pass++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_ack(1'b1, 10, cr);
    n_checks++; if (cr < 0) $display("FAIL stall_release_ack: got timeout expected ack"); else n_pass++;
    if (cr >= 0) sent_q.push_back(8'h05);
    n_checks++; if (level !== 3'(exp_level()) || exp_level() != DEPTH)
      $display("FAIL stall_level: got %0d expected %0d", level, DEPTH); else n_pass++;
    data_in = 8'($urandom);
    so_req  = 1'b0;
    wait_ack(1'b0, 10, cf);
    n_checks++; if (cf != SS + 1) $display("FAIL stall_ack_fall: got %0d expected %0d", cf, SS + 1); else n_pass++;
    check_order("stall");
  endtask

  task automatic test_drain();
    drain(20);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL drain_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (level !== '0) $display("FAIL drain_level: got %0d expected 0", level); else n_pass++;
    n_checks++; if (popped_q.size() - pop_base != 5) $display("FAIL drain_count: got %0d expected 5", popped_q.size() - pop_base); else n_pass++;
    check_order("drain");
  endtask

  task automatic test_simul_push_pop();
    int cr, cf;
    do_reset();
    send_token(8'h10, 20, cr, cf);
    send_token(8'h11, 20, cr, cf);
    n_checks++; if (level !== 3'd2) $display("FAIL simul_pre_level: got %0d expected 2", level); else n_pass++;
    data_in = 8'h12;
    so_req  = 1'b1;
    tick(); tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (si_ack !== 1'b1) $display("FAIL simul_push: got ack %b expected 1", si_ack); else n_pass++;
    if (si_ack === 1'b1) sent_q.push_back(8'h12);
    n_checks++; if (level !== 3'd2) $display("FAIL simul_level: got %0d expected 2", level); else n_pass++;
    so_req = 1'b0;
    wait_ack(1'b0, 10, cf);
    drain(20);
    check_order("simul");
  endtask

  task automatic test_random();
    int cr, cf;
    logic [7:0] d;
    do_reset();
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      send_token(d, 100, cr, cf);
      n_checks++; if (cr < 0 || cf < 0) $display("FAIL rand_hs_%0d: got rise %0d fall %0d expected both >= 0", i, cr, cf); else n_pass++;
      n_checks++; if (level !== 3'(exp_level())) $display("FAIL rand_level_%0d: got %0d expected %0d", i, level, exp_level()); else n_pass++;
    end
    rand_rdy = 1'b0;
    drain(20);
    n_checks++; if (xfer_cnt !== 16'(exp_xfer())) $display("FAIL rand_xfer_cnt: got %0d expected %0d", xfer_cnt, exp_xfer()); else n_pass++;
    check_order("rand");
  endtask

  task automatic test_reset_mid();
    int cr, cf;
    do_reset();
    data_in = 8'h77;
    so_req  = 1'b1;
    wait_ack(1'b1, 10, cr);
    n_checks++; if (cr != SS + 1) $display("FAIL mid_first_ack: got %0d expected %0d", cr, SS + 1); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (si_ack !== 1'b0) $display("FAIL mid_async_ack: got %b expected 0", si_ack); else n_pass++;
    n_checks++; if (level !== '0) $display("FAIL mid_level: got %0d expected 0", level); else n_pass++;
    n_checks++; if (xfer_cnt !== 16'd0) $display("FAIL mid_xfer_cnt: got %0d expected 0", xfer_cnt); else n_pass++;
    tick();
    rst_n = 1'b1;
    mark_bases();
    data_in = 8'h88;
    wait_ack(1'b1, 10, cr);
    n_checks++; if (cr != SS + 1) $display("FAIL mid_reaccept: got %0d expected %0d", cr, SS + 1); else n_pass++;
    if (cr >= 0) sent_q.push_back(8'h88);
    n_checks++; if (xfer_cnt !== 16'(exp_xfer()) || exp_xfer() != 1)
      $display("FAIL mid_xfer_after: got %0d expected 1", xfer_cnt); else n_pass++;
    n_checks++; if (out_data !== 8'h88) $display("FAIL mid_out_data: got %0h expected 88", out_data); else n_pass++;
    so_req = 1'b0;
    wait_ack(1'b0, 10, cf);
    drain(10);
    check_order("mid");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_stall();
    test_drain();
    test_simul_push_pop();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
